aer_event_receiver: RTL

- Receive end of the AER event link driven by the pixel hierarchy.
- Accepts packed event words {row address, column address, timestamp, polarity} while the link's active qualifier is high.
- Discards repeated words, buffers events in a small FIFO, and decodes each word back into fields plus a one-hot pixel strobe.
- Downstream consumers (frame accumulator, host interface) drain it through a valid/ready handshake; overflow and timestamp wrap are reported.

---
 rtl/lib_arbiter_pkg.sv | 37 +++
 rtl/aer_event_fifo.sv | 61 ++++++
 rtl/aer_event_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lib_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lib_arbiter_pkg
// Shared layout constants for the AER event link between the pixel arbiter
// hierarchy and its receivers.
//   ROWS/COLS         : pixel array geometry
//   ROW_ADD/COL_ADD   : address field widths
//   SIZE              : timestamp width
//   WIDTH             : packed link word width
//   *_LSB             : field offsets inside the packed word
//   aer_event_t       : packed view of one link word
// -----------------------------------------------------------------------------
package lib_arbiter_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int ROW_ADD = 2;
    localparam int COL_ADD = 2;
    localparam int SIZE    = 8;
    localparam int WIDTH   = ROW_ADD + COL_ADD + SIZE + 1;

    // Width implied by the field list; receivers check it against WIDTH.
    localparam int AER_WIDTH = ROW_ADD + COL_ADD + SIZE + 1;

    // Word layout, MSB to LSB: {x_add, y_add, timestamp, polarity}
    localparam int POL_LSB = 0;
    localparam int TS_LSB  = POL_LSB + 1;
    localparam int Y_LSB   = TS_LSB + SIZE;
    localparam int X_LSB   = Y_LSB + COL_ADD;

    typedef struct packed {
        logic [ROW_ADD-1:0] x_add;
        logic [COL_ADD-1:0] y_add;
        logic [SIZE-1:0]    timestamp;
        logic               polarity;
    } aer_event_t;

endpackage

// File: rtl/aer_event_fifo.sv
// -----------------------------------------------------------------------------
// aer_event_fifo
// Generic first-word-fall-through FIFO with registered storage.
//   clk_i, reset_i : clock, asynchronous active-low reset
//   push_i, wr_data_i : write strobe and data (caller never pushes when full
//                       unless popping in the same cycle)
//   pop_i          : remove the head entry (caller only pops when not empty)
//   rd_data_o      : head entry, forced to zero while empty
//   full_o, empty_o, level_o : status
// -----------------------------------------------------------------------------
module aer_event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/aer_event_receiver.sv
// -----------------------------------------------------------------------------
// aer_event_receiver
// Receive end of the AER event link. Deduplicates held words, buffers events,
// counts drops on overflow, flags timestamp wrap and decodes the head event.
//   clk_i, reset_i     : clock, asynchronous active-low reset
//   data_in_i, valid_i : packed link word and its active qualifier
//   clr_i              : synchronous clear of drop_cnt_o / overflow_o
//   evt_valid_o, evt_ready_i : consumer handshake
//   x_add_o, y_add_o, timestamp_o, polarity_o : head event fields
//   pix_strobe_o       : one-hot [x][y] during a pop, zero otherwise
//   ts_wrap_o          : one-cycle pulse after a push whose timestamp went back
//   overflow_o, drop_cnt_o : sticky drop flag and saturating drop count
//   fifo_level_o       : buffer occupancy
//
// Handshake: evt_valid_o is high whenever an event is buffered; the head event
// is transferred on a clock edge where evt_valid_o && evt_ready_i. While
// evt_valid_o is high and evt_ready_i is low the head fields hold stable.
// -----------------------------------------------------------------------------
module aer_event_receiver
    import lib_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [WIDTH-1:0]                data_in_i,
    input  logic                            valid_i,
    input  logic                            clr_i,
    input  logic                            evt_ready_i,
    output logic                            evt_valid_o,
    output logic [ROW_ADD-1:0]              x_add_o,
    output logic [COL_ADD-1:0]              y_add_o,
    output logic [SIZE-1:0]                 timestamp_o,
    output logic                            polarity_o,
    output logic [ROWS*COLS-1:0]            pix_strobe_o,
    output logic                            ts_wrap_o,
    output logic                            overflow_o,
    output logic [DROP_CNT_W-1:0]           drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

    if ((AER_WIDTH != WIDTH) || (X_LSB + ROW_ADD != WIDTH) ||
        ($bits(aer_event_t) != WIDTH)) begin : g_width_check
        $error("aer_event_receiver: AER word layout does not match WIDTH");
    end

    logic                  prev_valid_q;
    logic [WIDTH-1:0]      prev_word_q;
    logic [SIZE-1:0]       ts_last_q, ts_last_d;
    logic                  ts_seen_q, ts_seen_d;
    logic                  ts_wrap_q, ts_wrap_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  new_evt, push, pop, drop;
    logic                  fifo_full, fifo_empty;
    logic [WIDTH-1:0]      head_word;
    logic [SIZE-1:0]       in_ts;
    aer_event_t            head;

    // A word held across consecutive active cycles is one event.
    assign new_evt = valid_i && !(prev_valid_q && (data_in_i == prev_word_q));
    assign pop     = evt_valid_o && evt_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = new_evt && (!fifo_full || pop);
    assign drop    = new_evt && fifo_full && !pop;
    assign in_ts   = data_in_i[TS_LSB +: SIZE];

    aer_event_fifo #(
        .DATA_W (WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (push),
        .wr_data_i (data_in_i),
        .pop_i     (pop),
        .rd_data_o (head_word),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level_o)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clr_i) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end
        // Drop applied after clear so a same-cycle drop is still recorded.
        if (drop) begin
            overflow_d = 1'b1;
            if (!(&drop_cnt_d)) drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
        end
        ts_wrap_d = push && ts_seen_q && (in_ts < ts_last_q);
        ts_last_d = push ? in_ts : ts_last_q;
        ts_seen_d = ts_seen_q || push;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            prev_valid_q <= 1'b0;
            prev_word_q  <= '0;
            ts_last_q    <= '0;
            ts_seen_q    <= 1'b0;
            ts_wrap_q    <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            prev_valid_q <= valid_i;
            prev_word_q  <= data_in_i;
            ts_last_q    <= ts_last_d;
            ts_seen_q    <= ts_seen_d;
            ts_wrap_q    <= ts_wrap_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign head        = aer_event_t'(head_word);
    assign evt_valid_o = !fifo_empty;
    assign x_add_o     = head.x_add;
    assign y_add_o     = head.y_add;
    assign timestamp_o = head.timestamp;
    assign polarity_o  = head.polarity;
    assign ts_wrap_o   = ts_wrap_q;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

    // Addresses outside the array match no (r, c) pair and give no strobe.
    always_comb begin
        pix_strobe_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pix_strobe_o[r*COLS + c] = pop && (int'(head.x_add) == r) &&
                                           (int'(head.y_add) == c);
            end
        end
    end

endmodule
